// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared funct3 encodings, FSM state encoding and instruction size.
package branch_resolve_pkg;
    localparam int INSN_BYTES = 4;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;
endpackage

// File: rtl/branch_resolve_decide.sv
// branch_decide: combinational condition decode and redirect target computation.
module branch_decide
    import branch_resolve_pkg::*;
(
    input  logic        is_branch_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic        br_eq_i,
    input  logic        br_lt_i,
    output logic        taken,
    output logic [31:0] target,
    output logic        misalign,
    output logic        illegal
);
    logic        cond_taken;
    logic        cond_ok;
    logic        use_rs1;
    logic [31:0] sum_pc;
    logic [31:0] sum_rs1;

    assign cond_taken = (funct3_i == F3_BEQ) ? br_eq_i :
                        (funct3_i == F3_BNE) ? !br_eq_i :
                        (funct3_i == F3_BLT || funct3_i == F3_BLTU) ? br_lt_i :
                        (funct3_i == F3_BGE || funct3_i == F3_BGEU) ? !br_lt_i : 1'b0;
    assign cond_ok    = funct3_i != 3'b010 && funct3_i != 3'b011;
    // JAL outranks JALR, which outranks a conditional branch
    assign use_rs1    = !is_jal_i && is_jalr_i;
    assign sum_pc     = pc_i + imm_i;
    assign sum_rs1    = rs1_i + imm_i;
    assign illegal    = is_branch_i && !is_jal_i && !is_jalr_i && !cond_ok;
    assign taken      = is_jal_i || is_jalr_i || (is_branch_i && cond_ok && cond_taken);
    assign target     = use_rs1 ? {sum_rs1[31:1], 1'b0} : sum_pc;
    assign misalign   = taken && target[1];
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution with redirect handshake, flush window
// and saturating taken-redirect counter.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_is_branch,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_rs1,
    input  logic             brEq,
    input  logic             brLT,
    output logic             brUn,
    input  logic             i_redir_ready,
    output logic             o_redir_valid,
    output logic [31:0]      o_redir_pc,
    output logic             o_flush,
    output logic             o_stall,
    output logic [31:0]      o_link_pc,
    output logic             o_misalign,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_taken_cnt
);
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    state_e           state_q;
    logic             redir_valid_q;
    logic [31:0]      redir_pc_q;
    logic             flush_q;
    logic             stall_q;
    logic             misalign_q;
    logic             illegal_q;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;
    logic [3:0]       fcnt_q;
    logic             taken;
    logic [31:0]      target;
    logic             misalign;
    logic             illegal;

    branch_decide u_decide (
        .is_branch_i (i_is_branch),
        .is_jal_i    (i_is_jal),
        .is_jalr_i   (i_is_jalr),
        .funct3_i    (i_funct3),
        .pc_i        (i_pc),
        .imm_i       (i_imm),
        .rs1_i       (i_rs1),
        .br_eq_i     (brEq),
        .br_lt_i     (brLT),
        .taken       (taken),
        .target      (target),
        .misalign    (misalign),
        .illegal     (illegal)
    );

    assign brUn        = i_funct3[1];
    assign o_link_pc   = i_pc + 32'(INSN_BYTES);
    assign taken_cnt_d = (&taken_cnt_q) ? taken_cnt_q : taken_cnt_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            misalign_q    <= 1'b0;
            illegal_q     <= 1'b0;
            taken_cnt_q   <= '0;
            fcnt_q        <= '0;
        end else begin
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (illegal) begin
                            illegal_q <= 1'b1;
                        end else if (taken && misalign) begin
                            misalign_q <= 1'b1;
                        end else if (taken) begin
                            redir_pc_q    <= target;
                            redir_valid_q <= 1'b1;
                            stall_q       <= 1'b1;
                            state_q       <= ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (i_redir_ready) begin
                        redir_valid_q <= 1'b0;
                        taken_cnt_q   <= taken_cnt_d;
                        fcnt_q        <= FLUSH_LD;
                        flush_q       <= 1'b1;
                        state_q       <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    fcnt_q <= fcnt_q - 1'b1;
                    if (fcnt_q == 4'd1) begin
                        flush_q <= 1'b0;
                        stall_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_redir_valid = redir_valid_q;
    assign o_redir_pc    = redir_pc_q;
    assign o_flush       = flush_q;
    assign o_stall       = stall_q;
    assign o_misalign    = misalign_q;
    assign o_illegal     = illegal_q;
    assign o_taken_cnt   = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: table vectors, hand sequences and random transactions checked
// against a transaction-level model of branch resolution.
module tb_branch_resolve;
    localparam int FC = 2;
    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          i_is_branch;
    logic          i_is_jal;
    logic          i_is_jalr;
    logic [2:0]    i_funct3;
    logic [31:0]   i_pc;
    logic [31:0]   i_imm;
    logic [31:0]   i_rs1;
    logic          brEq;
    logic          brLT;
    logic          brUn;
    logic          i_redir_ready;
    logic          o_redir_valid;
    logic [31:0]   o_redir_pc;
    logic          o_flush;
    logic          o_stall;
    logic [31:0]   o_link_pc;
    logic          o_misalign;
    logic          o_illegal;
    logic [CW-1:0] o_taken_cnt;

    int checks = 0;
    int errors = 0;
    int mcnt   = 0;

    typedef struct {
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1;
        logic        eq, lt;
        int          kind;   // 0 none, 1 redirect, 2 misalign, 3 illegal
        logic [31:0] tgt;
    } vec_t;

    vec_t tbl[14];

    branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_is_branch   (i_is_branch),
        .i_is_jal      (i_is_jal),
        .i_is_jalr     (i_is_jalr),
        .i_funct3      (i_funct3),
        .i_pc          (i_pc),
        .i_imm         (i_imm),
        .i_rs1         (i_rs1),
        .brEq          (brEq),
        .brLT          (brLT),
        .brUn          (brUn),
        .i_redir_ready (i_redir_ready),
        .o_redir_valid (o_redir_valid),
        .o_redir_pc    (o_redir_pc),
        .o_flush       (o_flush),
        .o_stall       (o_stall),
        .o_link_pc     (o_link_pc),
        .o_misalign    (o_misalign),
        .o_illegal     (o_illegal),
        .o_taken_cnt   (o_taken_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic br, jal, jalr, input logic [2:0] f3,
                                input logic [31:0] pc, imm, rs1, input logic eq, lt,
                                input int kind, input logic [31:0] tgt);
        vec_t v;
        v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3;
        v.pc = pc; v.imm = imm; v.rs1 = rs1; v.eq = eq; v.lt = lt;
        v.kind = kind; v.tgt = tgt;
        return v;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit tk = 0;
        bit ill = 0;
        logic [31:0] t = v.pc + v.imm;
        if (v.jal) tk = 1;
        else if (v.jalr) begin
            tk = 1;
            t = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
        end else if (v.br) begin
            case (v.f3)
                3'd0: tk = v.eq;
                3'd1: tk = !v.eq;
                3'd4, 3'd6: tk = v.lt;
                3'd5, 3'd7: tk = !v.lt;
                default: ill = 1;
            endcase
        end
        r.tgt  = t;
        r.kind = ill ? 3 : !tk ? 0 : t[1] ? 2 : 1;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        i_is_branch = v.br; i_is_jal = v.jal; i_is_jalr = v.jalr; i_funct3 = v.f3;
        i_pc = v.pc; i_imm = v.imm; i_rs1 = v.rs1; brEq = v.eq; brLT = v.lt;
    endtask

    task automatic junk();
        i_valid = 1'b1;
        i_is_branch = 1'($urandom); i_is_jal = 1'($urandom); i_is_jalr = 1'($urandom);
        i_funct3 = 3'($urandom); i_pc = $urandom; i_imm = $urandom; i_rs1 = $urandom;
        brEq = 1'($urandom); brLT = 1'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " rv"}, o_redir_valid, 0);
        chk({tag, " rpc"}, o_redir_pc, 0);
        chk({tag, " flush"}, o_flush, 0);
        chk({tag, " stall"}, o_stall, 0);
        chk({tag, " mis"}, o_misalign, 0);
        chk({tag, " ill"}, o_illegal, 0);
        chk({tag, " cnt"}, 32'(o_taken_cnt), 0);
    endtask

    task automatic run_txn(input vec_t v, input int wt, input string tag);
        drive(v);
        i_valid = 1'b1;
        i_redir_ready = 1'b1;  // ready during the decision cycle must not count
        #1;
        chk({tag, " brUn"}, brUn, v.f3[1]);
        chk({tag, " link"}, o_link_pc, v.pc + 32'd4);
        step();
        i_valid = 1'b0;
        i_redir_ready = 1'b0;
        chk({tag, " rv"}, o_redir_valid, v.kind == 1);
        chk({tag, " mis"}, o_misalign, v.kind == 2);
        chk({tag, " ill"}, o_illegal, v.kind == 3);
        chk({tag, " stall"}, o_stall, v.kind == 1);
        if (v.kind == 1) begin
            chk({tag, " rpc"}, o_redir_pc, v.tgt);
            for (int k = 0; k < wt; k++) begin
                junk();
                i_redir_ready = 1'b0;
                step();
                chk({tag, " wait rv"}, o_redir_valid, 1);
                chk({tag, " wait rpc"}, o_redir_pc, v.tgt);
                chk({tag, " wait flush"}, o_flush, 0);
                chk({tag, " wait mis"}, o_misalign | o_illegal, 0);
            end
            i_valid = 1'b0;
            i_redir_ready = 1'b1;
            step();
            i_redir_ready = 1'b0;
            mcnt = (mcnt < (1 << CW) - 1) ? mcnt + 1 : mcnt;
            for (int k = 0; k < FC; k++) begin
                chk({tag, " flush"}, o_flush, 1);
                chk({tag, " fl stall"}, o_stall, 1);
                chk({tag, " fl rv"}, o_redir_valid, 0);
                chk({tag, " fl mis"}, o_misalign | o_illegal, 0);
                chk({tag, " cnt"}, 32'(o_taken_cnt), mcnt);
                junk();
                step();
            end
            i_valid = 1'b0;
            chk({tag, " end flush"}, o_flush, 0);
            chk({tag, " end stall"}, o_stall, 0);
            chk({tag, " end mis"}, o_misalign | o_illegal, 0);
        end else begin
            step();
            chk({tag, " pulse"}, o_misalign | o_illegal, 0);
            chk({tag, " idle rv"}, o_redir_valid, 0);
            chk({tag, " idle stall"}, o_stall, 0);
        end
        chk({tag, " cnt idle"}, 32'(o_taken_cnt), mcnt);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 1, 0, 1, 32'h120);
        tbl[1]  = mk(1, 0, 0, 3'b110, 32'h100, 32'h20, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 3'b000, 32'h500, 32'h1, 32'h203, 0, 0, 1, 32'h204);
        tbl[3]  = mk(0, 0, 1, 3'b000, 32'h500, 32'h1, 32'h201, 0, 0, 2, 0);
        tbl[4]  = mk(1, 0, 0, 3'b001, 32'h400, 32'hFFFF_FFF0, 0, 0, 0, 1, 32'h3F0);
        tbl[5]  = mk(1, 0, 0, 3'b100, 32'h1000, 32'h8, 0, 0, 1, 1, 32'h1008);
        tbl[6]  = mk(1, 0, 0, 3'b101, 32'h1000, 32'h8, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 3'b010, 32'h1000, 32'h8, 0, 1, 1, 3, 0);
        tbl[8]  = mk(1, 0, 0, 3'b011, 32'h1000, 32'h8, 0, 0, 0, 3, 0);
        tbl[9]  = mk(0, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'h8, 0, 0, 0, 1, 32'h4);
        tbl[10] = mk(1, 1, 1, 3'b010, 32'h200, 32'h10, 32'h7, 0, 0, 1, 32'h210);
        tbl[11] = mk(0, 1, 0, 3'b000, 32'h100, 32'h6, 0, 0, 0, 2, 0);
        tbl[12] = mk(0, 0, 0, 3'b000, 32'h100, 32'h20, 0, 1, 1, 0, 0);
        tbl[13] = mk(1, 0, 1, 3'b011, 32'h100, 32'h0, 32'h300, 0, 0, 1, 32'h300);

        // reset, with a taken JAL presented to show reset wins
        i_rst_n = 1'b0; i_redir_ready = 1'b0;
        drive(mk(0, 1, 0, 3'b000, 32'h100, 32'h20, 0, 0, 0, 0, 0));
        i_valid = 1'b1;
        step();
        step();
        check_zero("reset");
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        step();

        // reset during the first flush cycle
        drive(tbl[0]); i_valid = 1'b1;
        step();
        i_valid = 1'b0; i_redir_ready = 1'b1;
        step();
        i_redir_ready = 1'b0;
        chk("rstfl pre flush", o_flush, 1);
        i_rst_n = 1'b0;
        step();
        check_zero("rstfl");
        mcnt = 0;
        i_rst_n = 1'b1;
        step();

        // reset in REDIRECT coinciding with the handshake
        drive(tbl[0]); i_valid = 1'b1;
        step();
        i_valid = 1'b0; i_redir_ready = 1'b1; i_rst_n = 1'b0;
        step();
        check_zero("rstrd");
        i_redir_ready = 1'b0; i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) run_txn(tbl[i], i % 3, $sformatf("vec%0d", i));
        run_txn(tbl[0], 5, "hold5");

        for (int i = 0; i < 17; i++) begin
            v = mk(0, 1, 0, 3'b000, 32'(i * 16), 32'h40, 0, 0, 0, 1, 32'(i * 16 + 64));
            run_txn(v, 0, $sformatf("sat%0d", i));
        end
        chk("saturated", 32'(o_taken_cnt), 32'hF);

        for (int i = 0; i < 150; i++) begin
            int cls;
            cls = $urandom_range(0, 4);
            v.br   = (cls == 1) ? 1'b1 : (cls == 4) ? 1'($urandom) : 1'b0;
            v.jal  = (cls == 2) ? 1'b1 : (cls == 4) ? 1'($urandom) : 1'b0;
            v.jalr = (cls == 3) ? 1'b1 : (cls == 4) ? 1'($urandom) : 1'b0;
            v.f3 = 3'($urandom); v.pc = $urandom & 32'hFFFF_FFFC;
            v.imm = $urandom & 32'hFFFF_FFFE; v.rs1 = $urandom;
            v.eq = 1'($urandom); v.lt = 1'($urandom);
            run_txn(model(v), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
